// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
package vend_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2
  } state_e;

  // Product latched at the first accepted coin.
  typedef enum logic [1:0] {
    PROD_NONE    = 2'd0,
    PROD_STAR    = 2'd1,
    PROD_STRAITS = 2'd2
  } product_e;

  // Coin codes as seen on the coin input.
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5C   = 2'b01;
  localparam logic [1:0] COIN_10C  = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  // Prices in 5-cent units.
  localparam logic [2:0] STAR_PRICE    = 3'd3;
  localparam logic [2:0] STRAITS_PRICE = 3'd4;

  // Buzzer on-time in cycles, starting with the dispense cycle.
  localparam logic [1:0] BUZZ_CYCLES = 2'd3;

  // Segment pattern for digit 0, also the reset pattern.
  localparam logic [6:0] SSD_ZERO = 7'b0111111;

  // Value of a coin code in 5-cent units (0 for no coin / invalid code).
  function automatic logic [2:0] coin_units(input logic [1:0] code);
    logic [2:0] units;
    case (code)
      COIN_5C:  units = 3'd1;
      COIN_10C: units = 3'd2;
      default:  units = 3'd0;
    endcase
    return units;
  endfunction

  // Price of the latched product; with no product the price is
  // unreachable so a stray coin can never trigger a dispense.
  function automatic logic [2:0] price_of(input product_e prod);
    logic [2:0] price;
    case (prod)
      PROD_STAR:    price = STAR_PRICE;
      PROD_STRAITS: price = STRAITS_PRICE;
      default:      price = 3'd7;
    endcase
    return price;
  endfunction

endpackage

// File: rtl/vend_ssd_dec.sv
// Combinational credit-digit to 7-segment decoder, segments {g,f,e,d,c,b,a}.
module vend_ssd_dec
  import vend_pkg::*;
(
  input  logic [2:0] digit_i,
  output logic [6:0] seg_o
);

  // Map credit 0..5 to its glyph; anything larger is blanked.
  always_comb begin
    seg_o = 7'b0000000;
    case (digit_i)
      3'd0:    seg_o = SSD_ZERO;
      3'd1:    seg_o = 7'b0000110;
      3'd2:    seg_o = 7'b1011011;
      3'd3:    seg_o = 7'b1001111;
      3'd4:    seg_o = 7'b1100110;
      3'd5:    seg_o = 7'b1101101;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/vend.sv
// Two-product coin vending controller: credit accumulation, dispense,
// cancel/refund and error signalling, with every output registered.
module vend
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  input  logic       star_pb,
  input  logic       straits_pb,
  output logic       star_out,
  output logic       straits_out,
  output logic [6:0] ssd,
  output logic       green_led,
  output logic       red_led,
  output logic       buzzer
);

  state_e     state_q, state_d;
  product_e   prod_q, prod_d;
  logic [2:0] credit_q, credit_d;
  logic [1:0] buzz_cnt_q, buzz_cnt_d;
  logic       star_q, star_d;
  logic       straits_q, straits_d;
  logic       green_q, green_d;
  logic       red_q, red_d;
  logic       buzzer_q, buzzer_d;
  logic [6:0] ssd_q, ssd_d;

  logic       coin_valid;
  logic [2:0] coin_amt;
  logic [2:0] price;
  logic [3:0] credit_sum;
  logic       btn_held;

  assign coin_valid = (in == COIN_5C) || (in == COIN_10C);
  assign coin_amt   = coin_units(in);
  assign price      = price_of(prod_q);
  // One bit wider so the price comparison never wraps.
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_amt};
  assign btn_held   = (prod_q == PROD_STAR)    ? star_pb :
                      (prod_q == PROD_STRAITS) ? straits_pb : 1'b0;

  // The display follows the credit value that will be registered this edge.
  vend_ssd_dec u_ssd_dec (
    .digit_i (credit_d),
    .seg_o   (ssd_d)
  );

  // Next-state, credit and output decisions for the controller.
  always_comb begin
    state_d    = state_q;
    prod_d     = prod_q;
    credit_d   = credit_q;
    buzz_cnt_d = (buzz_cnt_q != 2'd0) ? (buzz_cnt_q - 2'd1) : 2'd0;
    star_d     = 1'b0;
    straits_d  = 1'b0;
    green_d    = 1'b0;
    red_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in == COIN_BAD) begin
          red_d = 1'b1;
        end else if (coin_valid) begin
          // Only an unambiguous single selection starts a purchase.
          if (star_pb ^ straits_pb) begin
            prod_d   = star_pb ? PROD_STAR : PROD_STRAITS;
            credit_d = coin_amt;
            state_d  = COLLECT;
          end else begin
            red_d = 1'b1;
          end
        end else begin
          red_d = 1'b0;
        end
      end

      COLLECT: begin
        // A completing coin wins over a released button.
        if (coin_valid && (credit_sum >= {1'b0, price})) begin
          state_d    = DISPENSE;
          credit_d   = 3'd0;
          star_d     = (prod_q == PROD_STAR);
          straits_d  = (prod_q == PROD_STRAITS);
          green_d    = 1'b1;
          buzz_cnt_d = BUZZ_CYCLES;
        end else if (!btn_held) begin
          state_d  = IDLE;
          prod_d   = PROD_NONE;
          credit_d = 3'd0;
          red_d    = 1'b1;
        end else if (coin_valid) begin
          credit_d = credit_sum[2:0];
        end else if (in == COIN_BAD) begin
          red_d = 1'b1;
        end else begin
          red_d = 1'b0;
        end
      end

      DISPENSE: begin
        state_d  = IDLE;
        prod_d   = PROD_NONE;
        credit_d = 3'd0;
        if (in != COIN_NONE) begin
          red_d = 1'b1;
        end else begin
          red_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        prod_d   = PROD_NONE;
        credit_d = 3'd0;
      end
    endcase

    buzzer_d = (buzz_cnt_d != 2'd0);
  end

  // State, credit and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prod_q     <= PROD_NONE;
      credit_q   <= 3'd0;
      buzz_cnt_q <= 2'd0;
      star_q     <= 1'b0;
      straits_q  <= 1'b0;
      green_q    <= 1'b0;
      red_q      <= 1'b0;
      buzzer_q   <= 1'b0;
      ssd_q      <= SSD_ZERO;
    end else begin
      state_q    <= state_d;
      prod_q     <= prod_d;
      credit_q   <= credit_d;
      buzz_cnt_q <= buzz_cnt_d;
      star_q     <= star_d;
      straits_q  <= straits_d;
      green_q    <= green_d;
      red_q      <= red_d;
      buzzer_q   <= buzzer_d;
      ssd_q      <= ssd_d;
    end
  end

  assign star_out    = star_q;
  assign straits_out = straits_q;
  assign green_led   = green_q;
  assign red_led     = red_q;
  assign buzzer      = buzzer_q;
  assign ssd         = ssd_q;

endmodule

// File: tb/tb_vend.sv
// Scoreboard bench for the vending controller: each stimulus row carries
// its expected output vector {star,straits,green,red,buzzer,ssd[6:0]}.
module tb_vend;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       star_pb;
  logic       straits_pb;
  logic       star_out;
  logic       straits_out;
  logic [6:0] ssd;
  logic       green_led;
  logic       red_led;
  logic       buzzer;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  coin;
    logic        sp;
    logic        tp;
    logic [11:0] exp;
  } stim_t;

  logic [11:0] exp_q[$];

  vend dut (
    .clk         (clk),
    .rst         (rst),
    .in          (coin),
    .star_pb     (star_pb),
    .straits_pb  (straits_pb),
    .star_out    (star_out),
    .straits_out (straits_out),
    .ssd         (ssd),
    .green_led   (green_led),
    .red_led     (red_led),
    .buzzer      (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ex(input logic so, input logic to, input logic g,
                                     input logic r, input logic b, input logic [6:0] s);
    return {so, to, g, r, b, s};
  endfunction

  function automatic logic [11:0] observed();
    return {star_out, straits_out, green_led, red_led, buzzer, ssd};
  endfunction

  function automatic stim_t mk(input logic [1:0] c, input logic sp, input logic tp,
                               input logic [11:0] e);
    stim_t s;
    s.coin = c; s.sp = sp; s.tp = tp; s.exp = e;
    return s;
  endfunction

  task automatic test_reset();
    logic [11:0] e;
    coin = 2'b10; star_pb = 1'b1; straits_pb = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, S0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL reset_hold: got %b expected %b", observed(), e);
    end
    @(negedge clk); rst = 1'b1; coin = 2'b00; star_pb = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, S0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", observed(), e);
    end
  endtask

  task automatic test_star();
    stim_t rows[$];
    logic [11:0] e;
    rows.push_back(mk(2'b01, 1, 0, ex(0, 0, 0, 0, 0, S1)));
    rows.push_back(mk(2'b10, 1, 0, ex(1, 0, 1, 0, 1, S0)));
    rows.push_back(mk(2'b00, 1, 0, ex(0, 0, 0, 0, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 0, S0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      coin = rows[i].coin; star_pb = rows[i].sp; straits_pb = rows[i].tp;
      exp_q.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL star step %0d: got %b expected %b", i, observed(), e);
      end
    end
  endtask

  task automatic test_straits();
    stim_t rows[$];
    logic [11:0] e;
    rows.push_back(mk(2'b01, 0, 1, ex(0, 0, 0, 0, 0, S1)));
    rows.push_back(mk(2'b10, 0, 1, ex(0, 0, 0, 0, 0, S3)));
    rows.push_back(mk(2'b10, 0, 1, ex(0, 1, 1, 0, 1, S0)));
    rows.push_back(mk(2'b10, 0, 1, ex(0, 0, 0, 1, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 0, S0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      coin = rows[i].coin; star_pb = rows[i].sp; straits_pb = rows[i].tp;
      exp_q.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL straits step %0d: got %b expected %b", i, observed(), e);
      end
    end
  endtask

  task automatic test_cancel();
    stim_t rows[$];
    logic [11:0] e;
    rows.push_back(mk(2'b01, 1, 0, ex(0, 0, 0, 0, 0, S1)));
    rows.push_back(mk(2'b01, 1, 0, ex(0, 0, 0, 0, 0, S2)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 1, 0, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 0, S0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      coin = rows[i].coin; star_pb = rows[i].sp; straits_pb = rows[i].tp;
      exp_q.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL cancel step %0d: got %b expected %b", i, observed(), e);
      end
    end
  endtask

  task automatic test_reject();
    stim_t rows[$];
    logic [11:0] e;
    rows.push_back(mk(2'b10, 1, 1, ex(0, 0, 0, 1, 0, S0)));
    rows.push_back(mk(2'b01, 0, 0, ex(0, 0, 0, 1, 0, S0)));
    rows.push_back(mk(2'b11, 1, 0, ex(0, 0, 0, 1, 0, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 0, S0)));
    // Invalid code while collecting keeps the credit.
    rows.push_back(mk(2'b01, 1, 0, ex(0, 0, 0, 0, 0, S1)));
    rows.push_back(mk(2'b11, 1, 0, ex(0, 0, 0, 1, 0, S1)));
    rows.push_back(mk(2'b00, 1, 0, ex(0, 0, 0, 0, 0, S1)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 1, 0, S0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      coin = rows[i].coin; star_pb = rows[i].sp; straits_pb = rows[i].tp;
      exp_q.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL reject step %0d: got %b expected %b", i, observed(), e);
      end
    end
  endtask

  task automatic test_priority();
    stim_t rows[$];
    logic [11:0] e;
    rows.push_back(mk(2'b01, 1, 0, ex(0, 0, 0, 0, 0, S1)));
    rows.push_back(mk(2'b01, 1, 1, ex(0, 0, 0, 0, 0, S2)));
    rows.push_back(mk(2'b10, 0, 1, ex(1, 0, 1, 0, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 0, S0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      coin = rows[i].coin; star_pb = rows[i].sp; straits_pb = rows[i].tp;
      exp_q.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL priority step %0d: got %b expected %b", i, observed(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t rows[$];
    logic [11:0] e;
    rows.push_back(mk(2'b01, 1, 0, ex(0, 0, 0, 0, 0, S1)));
    rows.push_back(mk(2'b10, 1, 0, ex(1, 0, 1, 0, 1, S0)));
    rows.push_back(mk(2'b00, 1, 0, ex(0, 0, 0, 0, 1, S0)));
    rows.push_back(mk(2'b10, 1, 0, ex(0, 0, 0, 0, 1, S2)));
    rows.push_back(mk(2'b01, 1, 0, ex(1, 0, 1, 0, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 1, S0)));
    rows.push_back(mk(2'b00, 0, 0, ex(0, 0, 0, 0, 0, S0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      coin = rows[i].coin; star_pb = rows[i].sp; straits_pb = rows[i].tp;
      exp_q.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL back_to_back step %0d: got %b expected %b", i, observed(), e);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t rows[$];
    logic [11:0] e;
    rows.push_back(mk(2'b01, 1, 0, ex(0, 0, 0, 0, 0, S1)));
    rows.push_back(mk(2'b01, 1, 0, ex(0, 0, 0, 0, 0, S2)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      coin = rows[i].coin; star_pb = rows[i].sp; straits_pb = rows[i].tp;
      exp_q.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (observed() !== e) begin
        n_fail++; $display("FAIL async_setup step %0d: got %b expected %b", i, observed(), e);
      end
    end
    // Mid-cycle reset in COLLECT with credit 2, no clock edge in between.
    #2; rst = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, S0));
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL async_collect: got %b expected %b", observed(), e);
    end
    // Credit must restart from zero after release.
    @(negedge clk); rst = 1'b1; coin = 2'b01; star_pb = 1'b1; straits_pb = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, S1));
    @(posedge clk); #1;
    e = exp_q.pop_front(); n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL async_restart: got %b expected %b", observed(), e);
    end
    @(negedge clk); coin = 2'b10;
    exp_q.push_back(ex(1, 0, 1, 0, 1, S0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL async_dispense: got %b expected %b", observed(), e);
    end
    // Reset during the dispense cycle must kill the buzzer for good.
    #2; rst = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, S0));
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL async_dispense_abort: got %b expected %b", observed(), e);
    end
    @(negedge clk); rst = 1'b1; coin = 2'b00; star_pb = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, S0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); n_checks++;
    if (observed() !== e) begin
      n_fail++; $display("FAIL async_buzzer_cancel: got %b expected %b", observed(), e);
    end
  endtask

  initial begin
    rst = 1'b0; coin = 2'b00; star_pb = 1'b0; straits_pb = 1'b0;
    test_reset();
    test_star();
    test_straits();
    test_cancel();
    test_reject();
    test_priority();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend.md
VEND -- requirements
Module: vend

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port in, input, 2 bits: coin code sampled each clock; 00 no coin, 01 5-cent, 10 10-cent, 11 invalid.
REQ-004 The module SHALL have port star_pb, input, 1 bit: Star selection, level-sensitive, high while held.
REQ-005 The module SHALL have port straits_pb, input, 1 bit: Straits selection, level-sensitive, high while held.
REQ-006 The module SHALL have port star_out, output, 1 bit: one-cycle Star dispense pulse.
REQ-007 The module SHALL have port straits_out, output, 1 bit: one-cycle Straits dispense pulse.
REQ-008 The module SHALL have port ssd, output, 7 bits: active-high segments {g,f,e,d,c,b,a} showing the credit digit.
REQ-009 The module SHALL have port green_led, output, 1 bit: high during the dispense cycle.
REQ-010 The module SHALL have port red_led, output, 1 bit: one-cycle error/cancel pulse.
REQ-011 The module SHALL have port buzzer, output, 1 bit: high for 3 cycles starting with the dispense cycle.

Function
REQ-012 The block SHALL keep credit in 5-cent units in a 3-bit register; prices are Star = 3 units (15c) and Straits = 4 units (20c).
REQ-013 The FSM SHALL have states IDLE, COLLECT and DISPENSE, and all outputs SHALL be registered.
REQ-014 Each clock with in = 01 or in = 10 SHALL count as one coin of 1 or 2 units; a held code counts again every cycle.
REQ-015 In IDLE, a valid coin with exactly one button high SHALL latch that product, load credit, and enter COLLECT.
REQ-016 In IDLE, a valid coin with no button or both buttons high SHALL be rejected: credit unchanged and red_led pulsed.
REQ-017 In COLLECT, valid coins SHALL add to credit; the latched product SHALL stay fixed and the other button SHALL be ignored.
REQ-018 When credit + coin >= price, the FSM SHALL enter DISPENSE on that edge; excess credit is forfeited.
REQ-019 In DISPENSE, for exactly one cycle, the latched product's out, green_led and buzzer SHALL be 1; credit SHALL clear and the FSM SHALL return to IDLE.
REQ-020 Coins arriving during DISPENSE SHALL be ignored and SHALL pulse red_led.
REQ-021 in = 11 in any state SHALL be ignored and SHALL pulse red_led.
REQ-022 In COLLECT, dropping the latched button with credit below price SHALL clear credit, pulse red_led (cancel/refund) and return to IDLE.
REQ-023 If the latched button drops and a coin completes the price on the same cycle, the dispense SHALL take priority over the cancel.
REQ-024 buzzer SHALL stay high for 3 consecutive cycles from the dispense cycle, driven by a 2-bit down-counter; a new dispense SHALL reload it.
REQ-025 ssd SHALL show credit 0..5: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, and any other value SHALL show 0000000.

Reset
REQ-026 While rst = 0, the block SHALL hold state IDLE, credit 0, product none and buzzer count 0.
REQ-027 While rst = 0, outputs SHALL be star_out = 0, straits_out = 0, green_led = 0, red_led = 0, buzzer = 0 and ssd = 0111111.
REQ-028 Reset asserted mid-operation SHALL abort immediately, forfeit credit and cancel any buzzer.

Structure
REQ-029 A shared package vend_pkg SHALL hold the state enum, coin codes, the price constants STAR_PRICE = 3 and STRAITS_PRICE = 4, and BUZZ_CYCLES = 3.
REQ-030 The design SHALL include one sub-module, vend_ssd_dec, a combinational 3-bit to 7-segment decoder.

Verification
REQ-031 Bench: star_pb = 1, then in = 01 then 10 on consecutive cycles -> one cycle later star_out = 1, green_led = 1, and buzzer high for 3 cycles.
REQ-032 Bench: straits_pb = 1, then in = 01, 10, 10, 10 -> straits_out pulses once after the third coin (25c), and the fourth coin pulses red_led.
REQ-033 Bench: star_pb = 1, in = 01, 01 (ssd = 1011011), then star_pb = 0 -> red_led pulse, credit 0, ssd = 0111111, no dispense.
REQ-034 Bench: both buttons high and in = 10, or in = 11 -> red_led pulse, state IDLE, ssd unchanged.
REQ-035 Bench: rst = 0 asserted asynchronously in COLLECT with credit 2 -> all outputs at reset values before the next clock edge.
